// File: rtl/rst_release_sequencer_if.sv
// Reset-sequencer sideband bundle.
// Groups the software restart request, per-stage ready acks and all
// sequencer status outputs so the sequencer and its user share one port.
//   sw_rst_req    : restart the whole release sequence
//   stage_ack     : per-stage ready acknowledge
//   stage_rst_out : active-high reset per stage
//   all_released  : every stage released and acked
//   busy          : sequence in progress
//   timeout_err   : sticky ack-timeout flag
//   cur_stage     : stage currently being released / awaited
// master = requester side (drives sw_rst_req/stage_ack), slave = sequencer.
interface rst_release_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst_out;
  logic                  all_released;
  logic                  busy;
  logic                  timeout_err;
  logic [CW-1:0]         cur_stage;

  modport master (
    output sw_rst_req, stage_ack,
    input  stage_rst_out, all_released, busy, timeout_err, cur_stage
  );

  modport slave (
    input  sw_rst_req, stage_ack,
    output stage_rst_out, all_released, busy, timeout_err, cur_stage
  );
endinterface

// File: rtl/rst_release_sequencer.sv
// Reset-release sequencer.
// Holds all downstream resets for HOLD_CYCLES after system reset, then
// releases stages one at a time in index order, waiting for each stage's
// ack and inserting GAP_CYCLES between an ack and the next release. A
// missing ack for ACK_TIMEOUT cycles re-asserts every stage reset and
// raises a sticky timeout_err. sw_rst_req restarts from HOLD in any state.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-low system reset
//   sq  : sideband bundle (slave modport), see rst_release_sequencer_if
module rst_release_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 5,
  parameter int GAP_CYCLES  = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst,
  rst_release_sequencer_if.slave sq
);
  localparam int CW = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  // Counters run 0..LAST and the terminal value triggers the transition,
  // so they never need to pass LAST.
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  all_rel_q, all_rel_d;
  logic                  busy_q, busy_d;
  logic                  terr_q, terr_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [CW-1:0]         cur_nxt;
  logic                  ack_sel;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    to_cnt_d    = to_cnt_q;
    stage_rst_d = stage_rst_q;
    all_rel_d   = all_rel_q;
    busy_d      = busy_q;
    terr_d      = terr_q;
    cur_d       = cur_q;
    cur_nxt     = cur_q + CW'(1);

    // Only the ack of the stage being awaited matters.
    ack_sel = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++)
      if (k == int'(cur_q)) ack_sel = sq.stage_ack[k];

    if (sq.sw_rst_req) begin
      // Restart overrides any same-cycle ack, timeout or gap expiry.
      state_d     = S_HOLD;
      hold_cnt_d  = '0;
      gap_cnt_d   = '0;
      to_cnt_d    = '0;
      stage_rst_d = '1;
      all_rel_d   = 1'b0;
      busy_d      = 1'b1;
      terr_d      = 1'b0;
      cur_d       = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            stage_rst_d[0] = 1'b0;
            to_cnt_d       = '0;
            state_d        = S_WAIT_ACK;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack_sel) begin
            if (cur_q == LAST_STAGE) begin
              state_d   = S_DONE;
              all_rel_d = 1'b1;
              busy_d    = 1'b0;
            end else if (GAP_CYCLES == 0) begin
              // No gap: next stage goes on the ack edge itself.
              for (int k = 0; k < NUM_STAGES; k++)
                if (k == int'(cur_nxt)) stage_rst_d[k] = 1'b0;
              cur_d    = cur_nxt;
              to_cnt_d = '0;
            end else begin
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end
          end else if (to_cnt_q == TO_LAST) begin
            state_d     = S_ERROR;
            stage_rst_d = '1;
            terr_d      = 1'b1;
            busy_d      = 1'b0;
            all_rel_d   = 1'b0;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            for (int k = 0; k < NUM_STAGES; k++)
              if (k == int'(cur_nxt)) stage_rst_d[k] = 1'b0;
            cur_d    = cur_nxt;
            to_cnt_d = '0;
            state_d  = S_WAIT_ACK;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        S_DONE: begin
          stage_rst_d = '0;
          all_rel_d   = 1'b1;
          busy_d      = 1'b0;
          cur_d       = LAST_STAGE;
        end
        S_ERROR: begin
          // Parked with all resets asserted until rst or sw_rst_req.
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stage_rst_q <= '1;
      all_rel_q   <= 1'b0;
      busy_q      <= 1'b1;
      terr_q      <= 1'b0;
      cur_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stage_rst_q <= stage_rst_d;
      all_rel_q   <= all_rel_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
      cur_q       <= cur_d;
    end
  end

  assign sq.stage_rst_out = stage_rst_q;
  assign sq.all_released  = all_rel_q;
  assign sq.busy          = busy_q;
  assign sq.timeout_err   = terr_q;
  assign sq.cur_stage     = cur_q;
endmodule

// File: doc/rst_release_sequencer.md
Name: rst_release_sequencer

Overview:
Reset-release sequencer for a chain of downstream blocks that each take an active-high reset.
- After the async system reset deasserts, it holds every downstream reset for a fixed number of cycles.
- It then releases the stages one at a time, in index order, and waits for each stage's ready acknowledge before inserting a gap and moving on.
- A stage reset, once released, stays deasserted until system reset, a software reset request or an error.

Parameters:
NUM_STAGES, 4, number of downstream reset domains (>=1)
HOLD_CYCLES, 5, posedges all resets stay asserted after rst deasserts (>=1)
GAP_CYCLES, 3, posedges between an accepted ack and the next stage release (>=0)
ACK_TIMEOUT, 16, posedges allowed in WAIT_ACK without ack before error (>=1)

Ports:
clk  input  1  system clock, posedge
rst  input  1  asynchronous, active-low reset
sw_rst_req  input  1  sampled at posedge; restarts the full sequence
stage_ack  input  NUM_STAGES  bit i: stage i ready after its reset release
stage_rst_out  output  NUM_STAGES  active-high reset per stage, registered
all_released  output  1  all stages released and acked, registered
busy  output  1  sequence in progress, registered
timeout_err  output  1  sticky ack-timeout flag, registered
cur_stage  output  max(1,$clog2(NUM_STAGES))  stage index being released or awaited

Behaviour:
- rst low (async): state=HOLD, hold_cnt=0, stage_rst_out=all 1s, all_released=0, busy=1, timeout_err=0, cur_stage=0.
- FSM states: HOLD, WAIT_ACK, GAP, DONE, ERROR. All outputs update only on posedge clk.
- HOLD: counts posedges with rst high.
  - On the HOLD_CYCLES-th posedge: stage_rst_out[0] cleared, next state WAIT_ACK.
  - Result: stage_rst_out[0] samples 1 at posedges 1..HOLD_CYCLES and 0 from posedge HOLD_CYCLES+1.
- WAIT_ACK (stage i):
  - Only stage_ack[i] is observed; other ack bits are ignored. The earliest sample is the posedge after the release edge; an ack already high counts.
  - Ack seen, i<NUM_STAGES-1: go to GAP. If GAP_CYCLES=0, stage i+1 is released on this same edge instead.
  - Ack seen, i=NUM_STAGES-1: go to DONE, all_released=1, busy=0 on that edge.
  - No ack on the ACK_TIMEOUT-th posedge in WAIT_ACK: go to ERROR.
- GAP: on the GAP_CYCLES-th posedge after the ack edge, clear stage_rst_out[i+1], cur_stage=i+1, go to WAIT_ACK.
- Monotonic release:
  - Stage j is never released before stage j-1 is acked.
  - A released bit never re-asserts except through rst, sw_rst_req or ERROR.
  - An ack dropping after acceptance has no effect.
- DONE: holds all stage_rst_out=0, all_released=1, busy=0, cur_stage=NUM_STAGES-1.
- ERROR:
  - On entry: stage_rst_out=all 1s, timeout_err=1 (sticky), busy=0, all_released=0, cur_stage frozen at the failing stage.
  - Stays in ERROR until rst or sw_rst_req.
- sw_rst_req=1 at a posedge:
  - Valid in any state, and has highest priority (overrides a same-cycle ack, timeout or gap expiry).
  - Effect on that edge: stage_rst_out=all 1s, all_released=0, busy=1, timeout_err=0, cur_stage=0, hold_cnt restarts, next state HOLD.
  - Holding it high keeps the block in HOLD with hold_cnt=0.
- Counter widths: hold, gap and timeout counters are sized for their parameters and saturate, never wrap.
- NUM_STAGES=1: the first ack goes straight to DONE.

Test Plan:
1. Defaults, all stage_ack=1, rst deasserted before posedge 1:
   - stage_rst_out[0] falls at edge 5; stage i falls at edge 5+4i, so stage 3 at edge 17.
   - all_released=1 and busy=0 at edge 18.
2. stage_ack[1] tied 0, others 1:
   - stage 1 released at edge 9, then 16 posedges without ack.
   - Edge 25: timeout_err=1, stage_rst_out=4'b1111, cur_stage=1, busy=0.
   - sw_rst_req pulse then clears timeout_err and restarts HOLD.
3. sw_rst_req pulse at edge 12 (stage 1 released, in GAP):
   - Edge 12: stage_rst_out=4'b1111, all_released=0.
   - stage 0 re-releases at edge 17 (12+5).
4. rst asserted low mid-sequence (edge 10):
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - After deassert, the timeline repeats scenario 1 relative to the new first posedge.
5. stage_ack[3:1] high before release, stage_ack[0] rising at edge 8:
   - Stage 1 stays in reset until edge 11 (8+GAP_CYCLES); no out-of-order release.
6. Property check:
   - After HOLD_CYCLES posedges of reset, no released bit rises again absent rst/sw_rst_req/timeout.
   - all_released implies stage_rst_out==0.
